// File: rtl/fwgpio_bridge_pkg.sv
// Shared types and constants for the rv_-to-Wishbone initiator bridge.
package fwgpio_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/fwgpio_bus_timer.sv
// Bus-cycle watchdog: counts cycles while enabled, flags expiry, and keeps a
// saturating tally of timeouts since reset.
module fwgpio_bus_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       count_inc,
    output logic       expire,
    output logic [7:0] timeout_cnt
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT == 0) begin : g_no_timer
            assign expire = 1'b0;
        end else begin : g_timer
            logic [TW-1:0] count;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable) begin
                    count <= count + TW'(1);
                end
            end

            // Fires on the TIMEOUT-th enabled cycle after a clear.
            assign expire = enable && (count == TW'(TIMEOUT - 1));
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_cnt <= 8'd0;
        end else if (count_inc && (timeout_cnt != 8'hFF)) begin
            timeout_cnt <= timeout_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/fwgpio_rv2wb_initiator.sv
// Bridges a held-valid / pulsed-ready request port onto a Wishbone B4
// classic initiator, one transaction outstanding, with a bus timeout.
module fwgpio_rv2wb_initiator
    import fwgpio_bridge_pkg::*;
#(
    parameter int               ADR_W    = 4,
    parameter int               DAT_W    = 32,
    parameter int               TIMEOUT  = 255,
    parameter logic [DAT_W-1:0] ERR_DATA = DAT_W'(ERR_DATA_DEFAULT)
) (
    input  logic               clock,
    input  logic               reset,
    // rv_valid is raised with a request and held until a one-cycle rv_ready;
    // rv_dat_r/rv_err are only meaningful while rv_ready is high.
    input  logic [ADR_W-1:0]   rv_adr,
    input  logic [DAT_W-1:0]   rv_dat_w,
    input  logic               rv_we,
    input  logic               rv_valid,
    output logic               rv_ready,
    output logic [DAT_W-1:0]   rv_dat_r,
    output logic               rv_err,
    output logic [ADR_W-1:0]   wb_adr,
    output logic [DAT_W-1:0]   wb_dat_w,
    input  logic [DAT_W-1:0]   wb_dat_r,
    output logic               wb_cyc,
    output logic               wb_stb,
    output logic               wb_we,
    output logic [DAT_W/8-1:0] wb_sel,
    input  logic               wb_ack,
    input  logic               wb_err,
    output logic [7:0]         timeout_cnt,
    output state_t             state_dbg
);

    state_t state, state_nxt;
    logic   latch_req;
    logic   bus_done;
    logic   hit_timeout;
    logic   tmr_expire;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion priority: ack over err over timeout.
    always_comb begin
        state_nxt   = state;
        latch_req   = 1'b0;
        bus_done    = 1'b0;
        hit_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (rv_valid) begin
                    latch_req = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (wb_ack || wb_err || tmr_expire) begin
                    bus_done    = 1'b1;
                    hit_timeout = !wb_ack && !wb_err;
                    state_nxt   = RESP;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_adr   <= '0;
            wb_dat_w <= '0;
            wb_we    <= 1'b0;
            rv_dat_r <= '0;
            rv_err   <= 1'b0;
        end else begin
            if (latch_req) begin
                wb_adr   <= rv_adr;
                wb_dat_w <= rv_dat_w;
                wb_we    <= rv_we;
            end
            if (bus_done) begin
                if (wb_ack) begin
                    rv_dat_r <= wb_we ? '0 : wb_dat_r;
                    rv_err   <= 1'b0;
                end else begin
                    rv_dat_r <= ERR_DATA;
                    rv_err   <= 1'b1;
                end
            end else if (state == RESP) begin
                rv_err <= 1'b0;
            end
        end
    end

    // Decoded straight from the state register so reset drops them at once.
    assign wb_cyc    = (state == BUS);
    assign wb_stb    = (state == BUS);
    assign rv_ready  = (state == RESP);
    assign wb_sel    = '1;
    assign state_dbg = state;

    fwgpio_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .clear       (latch_req),
        .enable      (state == BUS),
        .count_inc   (hit_timeout),
        .expire      (tmr_expire),
        .timeout_cnt (timeout_cnt)
    );

endmodule

// File: tb/tb_fwgpio_rv2wb_initiator.sv
// Directed self-checking bench for the rv_-to-Wishbone initiator bridge.
module tb_fwgpio_rv2wb_initiator;
    import fwgpio_bridge_pkg::*;

    logic        clock;
    logic        reset;
    logic [3:0]  rv_adr;
    logic [31:0] rv_dat_w;
    logic        rv_we;
    logic        rv_valid;
    logic        rv_ready;
    logic [31:0] rv_dat_r;
    logic        rv_err;
    logic [3:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_ack;
    logic        wb_err;
    logic [7:0]  timeout_cnt;
    state_t      state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    fwgpio_rv2wb_initiator #(
        .ADR_W   (4),
        .DAT_W   (32),
        .TIMEOUT (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rv_adr      (rv_adr),
        .rv_dat_w    (rv_dat_w),
        .rv_we       (rv_we),
        .rv_valid    (rv_valid),
        .rv_ready    (rv_ready),
        .rv_dat_r    (rv_dat_r),
        .rv_err      (rv_err),
        .wb_adr      (wb_adr),
        .wb_dat_w    (wb_dat_w),
        .wb_dat_r    (wb_dat_r),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_sel      (wb_sel),
        .wb_ack      (wb_ack),
        .wb_err      (wb_err),
        .timeout_cnt (timeout_cnt),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // kind: 0 ack, 1 err, 2 no response, 3 ack+err together
    task automatic run_txn(input logic [3:0] adr, input logic [31:0] wdat, input logic we,
                           input int waits, input int kind, input logic [31:0] rdat,
                           output int cyc_cycles, output int lat, output logic got_ready,
                           output logic got_err, output logic [31:0] got_dat,
                           output logic [3:0] last_adr, output logic [31:0] last_dat,
                           output logic last_we);
        logic resp;
        rv_adr     = adr;
        rv_dat_w   = wdat;
        rv_we      = we;
        rv_valid   = 1'b1;
        cyc_cycles = 0;
        lat        = 0;
        got_ready  = 1'b0;
        got_err    = 1'b0;
        got_dat    = '0;
        last_adr   = '0;
        last_dat   = '0;
        last_we    = 1'b0;
        tick;
        // the request is latched; scrambling the inputs must not leak through
        rv_adr   = ~adr;
        rv_dat_w = ~wdat;
        rv_we    = ~we;
        for (int i = 0; i < 40; i++) begin
            wb_ack = 1'b0;
            wb_err = 1'b0;
            wb_dat_r = 32'h0BAD_F00D;
            if (rv_ready) begin
                got_ready = 1'b1;
                got_err   = rv_err;
                got_dat   = rv_dat_r;
                lat       = i + 1;
                break;
            end
            if (wb_cyc && wb_stb) begin
                cyc_cycles++;
                last_adr = wb_adr;
                last_dat = wb_dat_w;
                last_we  = wb_we;
                resp = (cyc_cycles == waits + 1);
                if (resp && (kind == 0 || kind == 3)) begin
                    wb_ack   = 1'b1;
                    wb_dat_r = rdat;
                end
                if (resp && (kind == 1 || kind == 3)) wb_err = 1'b1;
            end
            tick;
        end
        rv_valid = 1'b0;
        tick;
    endtask

    task automatic scored_txn(input string tag, input logic [3:0] adr, input logic [31:0] wdat,
                              input logic we, input int waits, input int kind,
                              input logic [31:0] rdat, input logic [31:0] exp_dat,
                              input logic exp_err, input int exp_cyc, input int exp_lat);
        int cyc, lat;
        logic rdy, err, lwe;
        logic [31:0] dat, ldat;
        logic [3:0] ladr;
        exp_q.push_back(exp_dat);
        run_txn(adr, wdat, we, waits, kind, rdat, cyc, lat, rdy, err, dat, ladr, ldat, lwe);
        check({tag, "_ready"}, 32'(rdy), 32'd1);
        check({tag, "_cyc_len"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_wb_adr"}, 32'(ladr), 32'(adr));
        check({tag, "_wb_dat_w"}, ldat, wdat);
        check({tag, "_wb_we"}, 32'(lwe), 32'(we));
        check({tag, "_rv_err"}, 32'(err), 32'(exp_err));
        check({tag, "_rv_dat_r"}, dat, exp_q.pop_front());
        check({tag, "_ready_one_cycle"}, 32'(rv_ready), 32'd0);
        check({tag, "_err_cleared"}, 32'(rv_err), 32'd0);
        check({tag, "_dat_hold"}, rv_dat_r, exp_dat);
    endtask

    initial begin
        int cyc, lat;
        logic rdy, err, lwe, saw_ready;
        logic [31:0] dat, ldat;
        logic [3:0] ladr;

        reset    = 1'b0;
        rv_adr   = '0;
        rv_dat_w = '0;
        rv_we    = 1'b0;
        rv_valid = 1'b0;
        wb_dat_r = '0;
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        repeat (3) tick;

        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_wb_cyc", 32'(wb_cyc), 32'd0);
        check("rst_wb_stb", 32'(wb_stb), 32'd0);
        check("rst_rv_ready", 32'(rv_ready), 32'd0);
        check("rst_rv_dat_r", rv_dat_r, 32'd0);
        check("rst_wb_adr", 32'(wb_adr), 32'd0);
        check("rst_wb_sel", 32'(wb_sel), 32'hF);
        check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        reset = 1'b1;
        tick;

        // stray ack/err while idle must be ignored
        wb_ack = 1'b1;
        wb_err = 1'b1;
        tick;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        check("idle_ack_ignored", 32'(state_dbg), 32'(IDLE));
        check("idle_ack_no_ready", 32'(rv_ready), 32'd0);

        scored_txn("write", 4'h2, 32'h1234_5678, 1'b1, 0, 0, 32'hFFFF_FFFF,
                   32'h0, 1'b0, 1, 2);
        scored_txn("read3ws", 4'h9, 32'h0, 1'b0, 3, 0, 32'hA5A5_0F0F,
                   32'hA5A5_0F0F, 1'b0, 4, 5);
        scored_txn("ack_err", 4'h4, 32'h0, 1'b0, 1, 3, 32'h1357_9BDF,
                   32'h1357_9BDF, 1'b0, 2, 3);
        scored_txn("err_only", 4'hC, 32'h5555_AAAA, 1'b1, 0, 1, 32'h0,
                   32'hDEAD_BEEF, 1'b1, 1, 2);
        check("err_tcnt_unchanged", 32'(timeout_cnt), 32'd0);
        scored_txn("timeout", 4'h6, 32'h0, 1'b0, 0, 2, 32'h0,
                   32'hDEAD_BEEF, 1'b1, 8, 9);
        check("timeout_tcnt_1", 32'(timeout_cnt), 32'd1);

        // reset in the middle of a bus cycle
        rv_adr   = 4'h7;
        rv_dat_w = 32'h0;
        rv_we    = 1'b0;
        rv_valid = 1'b1;
        tick;
        tick;
        check("rst_mid_cyc_before", 32'(wb_cyc), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_cyc_drop", 32'(wb_cyc), 32'd0);
        check("rst_mid_stb_drop", 32'(wb_stb), 32'd0);
        check("rst_mid_tcnt", 32'(timeout_cnt), 32'd0);
        rv_valid = 1'b0;
        tick;
        reset = 1'b1;
        saw_ready = 1'b0;
        repeat (4) begin
            tick;
            if (rv_ready) saw_ready = 1'b1;
        end
        check("rst_mid_no_ready", 32'(saw_ready), 32'd0);
        scored_txn("post_rst_read", 4'h3, 32'h0, 1'b0, 0, 0, 32'hCAFE_0001,
                   32'hCAFE_0001, 1'b0, 1, 2);

        // back-to-back: valid held across rv_ready with a new address
        rv_adr   = 4'h3;
        rv_we    = 1'b0;
        rv_valid = 1'b1;
        tick;
        check("b2b_first_cyc", 32'(wb_cyc), 32'd1);
        wb_ack   = 1'b1;
        wb_dat_r = 32'h1111_2222;
        tick;
        wb_ack   = 1'b0;
        check("b2b_first_ready", 32'(rv_ready), 32'd1);
        check("b2b_first_dat", rv_dat_r, 32'h1111_2222);
        rv_adr = 4'h5;
        tick;
        check("b2b_gap_cyc", 32'(wb_cyc), 32'd0);
        tick;
        check("b2b_second_cyc", 32'(wb_cyc), 32'd1);
        check("b2b_second_adr", 32'(wb_adr), 32'h5);
        wb_ack   = 1'b1;
        wb_dat_r = 32'h3333_4444;
        tick;
        wb_ack   = 1'b0;
        rv_valid = 1'b0;
        check("b2b_second_ready", 32'(rv_ready), 32'd1);
        check("b2b_second_dat", rv_dat_r, 32'h3333_4444);
        tick;

        // timeout counter saturation
        for (int n = 0; n < 300; n++) begin
            run_txn(4'h1, 32'h0, 1'b0, 0, 2, 32'h0, cyc, lat, rdy, err, dat, ladr, ldat, lwe);
            if (n == 0) check("sat_first_err", 32'(err), 32'd1);
            if (n == 253) check("sat_tcnt_254", 32'(timeout_cnt), 32'd254);
            if (n == 254) check("sat_tcnt_255", 32'(timeout_cnt), 32'd255);
        end
        check("sat_tcnt_300", 32'(timeout_cnt), 32'd255);
        check("sat_last_dat", dat, 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fwgpio_rv2wb_initiator.md
Name: fwgpio_rv2wb_initiator

Overview:
Bridges the rv_ addr-line-enable request interface (initiator side: valid held until a ready pulse) onto a Wishbone B4 classic initiator port.
Lets a local controller, such as a sequencer or CPU shim, drive any WB target in the codebase, including fwgpio register banks.
Provides a registered single-outstanding transaction, a bus timeout with error return, and a saturating timeout counter.

Parameters:
ADR_W, 4, address width on both sides
DAT_W, 32, data width on both sides
TIMEOUT, 255, cycles in BUS without ack/err before abort; 0 disables timeout
ERR_DATA, 32'hDEAD_BEEF, rv_dat_r value returned on err or timeout

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-low reset
rv_adr  in  ADR_W  request address
rv_dat_w  in  DAT_W  write data
rv_we  in  1  1=write, 0=read
rv_valid  in  1  request present; held until rv_ready
rv_ready  out  1  one-cycle completion pulse
rv_dat_r  out  DAT_W  read data, valid while rv_ready=1
rv_err  out  1  completion was err/timeout; qualified by rv_ready
wb_adr  out  ADR_W  WB address
wb_dat_w  out  DAT_W  WB write data
wb_dat_r  in  DAT_W  WB read data
wb_cyc  out  1  WB cycle
wb_stb  out  1  WB strobe
wb_we  out  1  WB write enable
wb_sel  out  DAT_W/8  byte selects, always all ones
wb_ack  in  1  WB acknowledge
wb_err  in  1  WB error
timeout_cnt  out  8  saturating count of timeouts since reset

Behaviour:
- Reset (reset=0, async): state=IDLE; rv_ready=0, rv_err=0, rv_dat_r=0, wb_cyc=0, wb_stb=0, wb_we=0, wb_adr=0, wb_dat_w=0, timeout_cnt=0. wb_sel is constant all ones.
- Reset asserted mid-transaction drops wb_cyc/wb_stb immediately. No rv_ready is issued for the aborted request.
- FSM states: IDLE, BUS, RESP.
- IDLE: if rv_valid=1, register rv_adr, rv_dat_w, rv_we into the wb_* outputs, clear the timer and go to BUS. Otherwise stay.
- BUS: wb_cyc=wb_stb=1. The timer increments each cycle.
  - wb_ack=1: capture rv_dat_r = wb_dat_r for reads, 0 for writes; rv_err=0; go to RESP.
  - Else wb_err=1: rv_dat_r=ERR_DATA, rv_err=1, go to RESP.
  - Else TIMEOUT!=0 and timer==TIMEOUT-1: rv_dat_r=ERR_DATA, rv_err=1, timeout_cnt += 1 (saturates at 255), go to RESP.
  - Priority: ack > err > timeout when they coincide.
  - wb_cyc/wb_stb deassert on the cycle after ack/err/timeout is sampled.
- RESP: rv_ready=1 for exactly one cycle with rv_dat_r/rv_err stable. Next state is IDLE.
  - rv_dat_r holds its value until the next completion. rv_err clears when leaving RESP.
- Latency: rv_valid rising at cycle N, then wb_cyc/stb at N+1. With a zero-wait target (ack at N+1), rv_ready is at N+2. Minimum 3 cycles per transaction including the IDLE re-sample.
- Initiator contract: rv_valid must drop or change request in the cycle after rv_ready. If rv_valid is high in IDLE, that is a new request.
- wb_ack or wb_err outside BUS is ignored.
- rv_adr/rv_dat_w/rv_we changing while in BUS or RESP have no effect, because the request is latched.
- Timer width is clog2(TIMEOUT+1). When TIMEOUT=0 the timer logic is absent and BUS waits indefinitely.

Decomposition:
- Package fwgpio_bridge_pkg: state enum (IDLE, BUS, RESP) and the default ERR_DATA constant.
- One sub-module, fwgpio_bus_timer: clear, enable, expire output, parameterised by TIMEOUT, plus the saturating timeout_cnt.
- The FSM and datapath stay in the top module.

Test Plan:
- Write: rv_adr=4'h2, rv_dat_w=32'h1234_5678, rv_we=1, target acks on the first stb cycle -> wb_adr=2, wb_dat_w=32'h12345678, wb_we=1 for 1 cycle; rv_ready 2 cycles after valid; rv_err=0.
- Read with 3 wait states: target returns 32'hA5A5_0F0F -> wb_cyc held 4 cycles; rv_ready one cycle with rv_dat_r=32'hA5A50F0F, rv_err=0.
- Timeout: TIMEOUT=8, target never responds -> wb_cyc high exactly 8 cycles; rv_ready with rv_err=1, rv_dat_r=32'hDEADBEEF; timeout_cnt=1. Repeating 300 times -> timeout_cnt=255.
- wb_err and wb_ack in the same cycle -> ack wins, rv_err=0. wb_err alone -> rv_err=1, rv_dat_r=ERR_DATA, timeout_cnt unchanged.
- Reset asserted in BUS after 2 cycles -> wb_cyc/stb drop asynchronously, no rv_ready. After release, a new read completes normally.
- Back-to-back: valid held across rv_ready with a new address -> second wb_cyc starts 2 cycles after the first rv_ready, with the new address latched.
